lsu_byte_seq: RTL and testbench

LSU_BYTE_SEQ -- requirements
Module: lsu_byte_seq

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_ext.sv | 29 ++
 rtl/lsu_byte_seq.sv | 152 +++++++++++++++
 tb/tb_lsu_byte_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the byte-serial load/store unit: access sizes, FSM states
// and the size-to-byte-count helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    function automatic logic [3:0] lsu_nbytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/lsu_ext.sv
// Sign/zero extension of an assembled little-endian load value to XLEN bits.
// Sizes wider than XLEN return the raw data unchanged.
module lsu_ext
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] data_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] ext_o
);

    logic [6:0]      nbits;
    logic [XLEN-1:0] keep;
    logic            fill;

    always_comb begin
        nbits = {lsu_nbytes(size_i), 3'b000};
        if (nbits > 7'(XLEN)) begin
            nbits = 7'(XLEN);
        end
        // Shifting by XLEN wraps to zero, so the full-width mask falls out as all ones.
        keep  = (XLEN'(1) << nbits) - XLEN'(1);
        fill  = !unsigned_i && (|(data_i & (XLEN'(1) << (nbits - 7'd1))));
        ext_o = (data_i & keep) | ({XLEN{fill}} & ~keep);
    end

endmodule

// File: rtl/lsu_byte_seq.sv
// Byte-serial load/store sequencer in front of an 8-bit synchronous RAM.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned half/word/dword accesses with resp_err.
module lsu_byte_seq
    import lsu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rdy,
    // Request: accepted on a rising edge where req_valid && req_ready; all fields latched then.
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    input  logic [4:0]            req_rd,
    output logic                  ram_en,
    output logic                  ram_r_nw,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic [7:0]            ram_dout,
    input  logic [7:0]            ram_din,
    output logic                  resp_valid,
    output logic [4:0]            resp_rd,
    output logic [XLEN-1:0]       resp_rdata,
    output logic                  resp_err,
    output logic                  busy,
    output lsu_state_e            dbg_state_o
);

    lsu_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, uns_q, err_q, rd_pend_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [XLEN-1:0]       wdata_q, data_q, ext_data;
    logic [4:0]            rd_q;
    logic [2:0]            rd_idx_q;
    logic [3:0]            nbytes;
    logic                  accept, req_bad, issue;
    logic [31-ADDR_WIDTH:0] unused_addr_hi;

    assign unused_addr_hi = req_addr[31:ADDR_WIDTH];
    assign nbytes         = lsu_nbytes(size_q);
    assign req_ready      = (state_q == IDLE) && rdy;
    assign accept         = req_valid && req_ready;

    always_comb begin
        req_bad = (XLEN == 32) && (req_size == SIZE_D);
`ifdef LSU_MISALIGN_CHECK_EN
        if ((req_addr[2:0] & (3'(lsu_nbytes(req_size)) - 3'd1)) != 3'd0) begin
            req_bad = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = 4'd0;
                    if (req_bad)     state_d = RESP;
                    else if (req_we) state_d = STORE;
                    else             state_d = LOAD;
                end
            end
            LOAD: begin
                // One extra cycle after the last issue waits for its read byte.
                if (rdy) begin
                    if (cnt_q == nbytes) begin
                        state_d = RESP;
                    end else begin
                        issue = 1'b1;
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            STORE: begin
                if (rdy) begin
                    issue = 1'b1;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == nbytes - 4'd1) state_d = RESP;
                end
            end
            RESP: begin
                if (rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            err_q     <= 1'b0;
            size_q    <= 2'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= 5'd0;
            data_q    <= '0;
            rd_pend_q <= 1'b0;
            rd_idx_q  <= 3'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= issue && !we_q;
            rd_idx_q  <= cnt_q[2:0];
            // Capture runs regardless of rdy so a byte issued before a stall is not lost.
            if (rd_pend_q) begin
                data_q <= data_q | (XLEN'(ram_din) << {rd_idx_q, 3'b000});
            end
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                err_q   <= req_bad;
                size_q  <= req_size;
                addr_q  <= req_addr[ADDR_WIDTH-1:0];
                wdata_q <= req_wdata;
                rd_q    <= req_rd;
                data_q  <= '0;
            end
        end
    end

    lsu_ext #(.XLEN(XLEN)) u_ext (
        .data_i     (data_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .ext_o      (ext_data)
    );

    assign ram_en      = issue;
    assign ram_r_nw    = !(issue && we_q);
    assign ram_a       = issue ? (addr_q + ADDR_WIDTH'(cnt_q)) : '0;
    assign ram_dout    = (issue && we_q) ? 8'(wdata_q >> {cnt_q[2:0], 3'b000}) : 8'd0;
    assign resp_valid  = (state_q == RESP);
    assign resp_err    = resp_valid && err_q;
    assign resp_rdata  = (resp_valid && !err_q) ? ext_data : '0;
    assign resp_rd     = rd_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Self-checking bench for lsu_byte_seq: behavioural 1-cycle RAM, reference byte
// memory and expected-result queues popped when a response appears.
module tb_lsu_byte_seq;

    localparam int AW = 17;

    logic        clk, rst_n, rdy;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        ram_en, ram_r_nw;
    logic [AW-1:0] ram_a;
    logic [7:0]  ram_dout, ram_din;
    logic        resp_valid, resp_err, busy;
    logic [4:0]  resp_rd;
    logic [31:0] resp_rdata;
    logic [1:0]  dbg_state;

    logic [7:0]  mem     [0:(1<<AW)-1];
    logic [7:0]  ref_mem [0:(1<<AW)-1];
    int          en_cnt;
    int          n_checks, n_errors;
    logic [31:0] exp_q[$];
    logic [0:0]  exp_err_q[$];
    logic [7:0]  exp_lat_q[$];

    lsu_byte_seq dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .ram_en(ram_en), .ram_r_nw(ram_r_nw), .ram_a(ram_a),
        .ram_dout(ram_dout), .ram_din(ram_din),
        .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .busy(busy), .dbg_state_o(dbg_state)
    );

    // ---------------- clock / RAM model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_r_nw) ram_din <= mem[ram_a];
            else          mem[ram_a] <= ram_dout;
        end
    end

    always @(posedge clk) begin
        if (rst_n && ram_en) en_cnt <= en_cnt + 1;
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string p);
        check_val({p, "_resp_valid"}, resp_valid, 0);
        check_val({p, "_resp_rd"},    resp_rd,    0);
        check_val({p, "_resp_rdata"}, resp_rdata, 0);
        check_val({p, "_resp_err"},   resp_err,   0);
        check_val({p, "_busy"},       busy,       0);
        check_val({p, "_ram_en"},     ram_en,     0);
        check_val({p, "_ram_r_nw"},   ram_r_nw,   1);
        check_val({p, "_ram_a"},      ram_a,      0);
        check_val({p, "_ram_dout"},   ram_dout,   0);
        check_val({p, "_state"},      dbg_state,  0);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] addr);
        logic [63:0]   v;
        logic [AW-1:0] a;
        int            n;
        n = 1 << size;
        v = 64'd0;
        for (int k = 0; k < n; k++) begin
            a = AW'(addr + 32'(k));
            v = v | (64'(ref_mem[a]) << (8 * k));
        end
        if (n < 4 && !uns && ((v >> (8 * n - 1)) & 64'd1) == 64'd1) begin
            v = v | ~((64'd1 << (8 * n)) - 64'd1);
        end
        return v[31:0];
    endfunction

    task automatic model_store(input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata);
        logic [AW-1:0] a;
        for (int k = 0; k < (1 << size); k++) begin
            a = AW'(addr + 32'(k));
            ref_mem[a] = 8'(wdata >> (8 * k));
        end
    endtask

    // ---------------- driver ----------------
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                          input bit stall, input bit hold, output logic [31:0] got);
        int          n, lat, exp_lat, en0, w;
        logic        err;
        bit          do_stall;
        logic [31:0] erd;
        n   = 1 << size;
        err = (size == 2'd3);
`ifdef LSU_MISALIGN_CHECK_EN
        if ((addr & 32'(n - 1)) != 32'd0) err = 1'b1;
`endif
        if (err) begin
            erd = 32'd0; exp_lat = 1;
        end else if (we) begin
            model_store(size, addr, wdata); erd = 32'd0; exp_lat = n + 1;
        end else begin
            erd = model_load(size, uns, addr); exp_lat = n + 2;
        end
        do_stall = stall && (exp_lat >= 3);
        if (do_stall) exp_lat += 2;
        exp_q.push_back(erd);
        exp_err_q.push_back(err);
        exp_lat_q.push_back(8'(exp_lat));

        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk); w++;
        end
        check_val("req_ready", req_ready, 1);
        en0 = en_cnt;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (lat = 1; lat < 40; lat++) begin
            if (resp_valid) break;
            if (do_stall && lat == 2) begin
                rdy = 1'b0;
                #1;
                check_val("stall_ram_en", ram_en, 0);
            end
            if (do_stall && lat == 4) rdy = 1'b1;
            @(negedge clk);
        end
        got = resp_rdata;
        check_val("resp_valid_seen", resp_valid, 1);
        check_val("resp_latency", lat, exp_lat_q.pop_front());
        check_val("resp_rdata", resp_rdata, exp_q.pop_front());
        check_val("resp_err", resp_err, exp_err_q.pop_front());
        check_val("resp_rd", resp_rd, rd);
        check_val("busy_in_resp", busy, 1);
        check_val("ram_en_count", en_cnt - en0, err ? 0 : n);
        if (hold) begin
            rdy = 1'b0;
            repeat (2) begin
                @(negedge clk);
                check_val("resp_hold", resp_valid, 1);
            end
            rdy = 1'b1;
        end
        @(negedge clk);
        check_val("resp_pulse_end", resp_valid, 0);
        check_val("idle_busy", busy, 0);
        check_val("idle_r_nw", ram_r_nw, 1);
        check_val("idle_dout", ram_dout, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0]   got, a32;
        logic [1:0]    sz;
        int            en0;
        bit            seen;
        n_checks = 0; n_errors = 0; en_cnt = 0; ram_din = 8'd0;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = 8'(i * 37 + 11);
            ref_mem[i] = 8'(i * 37 + 11);
        end
        mem[17'h10] = 8'h34; ref_mem[17'h10] = 8'h34;
        mem[17'h11] = 8'h82; ref_mem[17'h11] = 8'h82;

        rst_n = 1'b0; rdy = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        do_req(1'b0, 2'd1, 1'b0, 32'h10, 32'd0, 5'd3, 0, 0, got);
        check_val("lh_0x10", got, 32'hFFFF8234);
        do_req(1'b0, 2'd1, 1'b1, 32'h10, 32'd0, 5'd4, 0, 0, got);
        check_val("lhu_0x10", got, 32'h00008234);
        do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'd0, 5'd5, 0, 0, got);
        check_val("lb_0x11", got, 32'hFFFFFF82);

        do_req(1'b1, 2'd2, 1'b0, 32'h1FFFE, 32'hDEADBEEF, 5'd6, 0, 0, got);
        check_val("sw_wrap_b0", mem[17'h1FFFE], 8'hEF);
        check_val("sw_wrap_b1", mem[17'h1FFFF], 8'hBE);
        check_val("sw_wrap_b2", mem[17'h00000], 8'hAD);
        check_val("sw_wrap_b3", mem[17'h00001], 8'hDE);
        do_req(1'b0, 2'd2, 1'b0, 32'h1FFFE, 32'd0, 5'd7, 0, 0, got);
        check_val("lw_wrap", got, 32'hDEADBEEF);

        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 5'd8, 1, 0, got);
        do_req(1'b0, 2'd2, 1'b0, 32'h21, 32'd0, 5'd9, 0, 0, got);
        do_req(1'b0, 2'd3, 1'b0, 32'h30, 32'd0, 5'd10, 0, 0, got);
        do_req(1'b1, 2'd0, 1'b0, 32'h50, 32'h000000A5, 5'd11, 0, 1, got);
        check_val("sb_mem", mem[17'h50], 8'hA5);

        // Reset in the middle of a word load, while the third byte is on the bus.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h40; req_rd = 5'd12;
        en0 = en_cnt;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        check_val("mid_reset_en_count", en_cnt - en0, 2);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check_val("no_resp_after_reset", seen, 0);
        do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 5'd13, 0, 0, got);

        for (int t = 0; t < 30; t++) begin
            sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a32 = $urandom;
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a32, $urandom,
                   5'($urandom_range(0, 31)), bit'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 3) == 0), got);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
